// File: rtl/sfx_tone_sequencer_pkg.sv
// rtl/sfx_tone_sequencer_pkg.sv - shared effect codes, FSM states and note-entry types
package sfx_pkg;

    localparam int CODE_WIDTH = 2;
    localparam int IDX_WIDTH  = 2;
    localparam int HP_WIDTH   = 8;
    localparam int DUR_WIDTH  = 14;

    localparam logic [CODE_WIDTH-1:0] SFX_PADDLE = 2'd0;
    localparam logic [CODE_WIDTH-1:0] SFX_BRICK  = 2'd1;
    localparam logic [CODE_WIDTH-1:0] SFX_LOST   = 2'd2;
    localparam logic [CODE_WIDTH-1:0] SFX_CLEAR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } sfx_state_e;

    typedef struct packed {
        logic [HP_WIDTH-1:0]  half_period;
        logic [DUR_WIDTH-1:0] duration;
    } note_t;

    // half_period of zero marks the end of an effect
    localparam note_t NOTE_TERM = '{half_period: '0, duration: '0};

    function automatic note_t mk_note(input int unsigned hp, input int unsigned dur);
        note_t n;
        n.half_period = HP_WIDTH'(hp);
        n.duration    = DUR_WIDTH'(dur);
        return n;
    endfunction

endpackage

// File: rtl/sfx_tone_sequencer_if.sv
// rtl/sfx_tone_sequencer_if.sv - trigger handshake and sample stream between game logic and sequencer
interface sfx_tone_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  iSample_Tick;
    logic                  iTrig_Valid;
    logic [1:0]            iTrig_Code;
    logic                  oTrig_Ready;
    logic [DATA_WIDTH-1:0] oSample;
    logic                  oSample_Valid;
    logic                  oBusy;

    modport master (
        output iSample_Tick,
        output iTrig_Valid,
        output iTrig_Code,
        input  oTrig_Ready,
        input  oSample,
        input  oSample_Valid,
        input  oBusy
    );

    modport slave (
        input  iSample_Tick,
        input  iTrig_Valid,
        input  iTrig_Code,
        output oTrig_Ready,
        output oSample,
        output oSample_Valid,
        output oBusy
    );
endinterface

// File: rtl/sfx_tone_sequencer_note_rom.sv
// rtl/sfx_tone_sequencer_note_rom.sv - effect note table, {code, index} to {half_period, duration}
module sfx_note_rom
    import sfx_pkg::*;
(
    input  logic [CODE_WIDTH-1:0] code,
    input  logic [IDX_WIDTH-1:0]  idx,
    output note_t                 note
);

    always_comb begin
        note = NOTE_TERM;
        case ({code, idx})
            {SFX_PADDLE, 2'd0}: note = mk_note(24, 2400);
            {SFX_BRICK,  2'd0}: note = mk_note(12, 1440);
            {SFX_BRICK,  2'd1}: note = mk_note(8,  1440);
            {SFX_LOST,   2'd0}: note = mk_note(48, 4800);
            {SFX_LOST,   2'd1}: note = mk_note(64, 4800);
            {SFX_LOST,   2'd2}: note = mk_note(96, 9600);
            {SFX_CLEAR,  2'd0}: note = mk_note(24, 2400);
            {SFX_CLEAR,  2'd1}: note = mk_note(18, 2400);
            {SFX_CLEAR,  2'd2}: note = mk_note(12, 2400);
            {SFX_CLEAR,  2'd3}: note = mk_note(9,  4800);
            default:            note = NOTE_TERM;
        endcase
    end

endmodule

// File: rtl/sfx_tone_sequencer.sv
// rtl/sfx_tone_sequencer.sv - plays sound effects as decaying square-wave notes, one PCM sample per frame tick
module sfx_tone_sequencer
    import sfx_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] AMP_MAX    = 16'h3FFF,
    parameter int                    DECAY_STEP = 512,
    parameter int                    MAX_NOTES  = 4
) (
    input  logic                iCLK_18_4,
    input  logic                iRST_N,
    sfx_tone_sequencer_if.slave bus
);

    localparam int                    DECAY_LOG2 = $clog2(DECAY_STEP);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX   = IDX_WIDTH'(MAX_NOTES - 1);

    sfx_state_e            state_q, state_d;
    logic [CODE_WIDTH-1:0] code_q, code_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [HP_WIDTH-1:0]   hp_q, hp_d;
    logic [DUR_WIDTH-1:0]  dur_q, dur_d;
    logic [HP_WIDTH-1:0]   phase_cnt_q, phase_cnt_d;
    logic [DUR_WIDTH-1:0]  elapsed_q, elapsed_d;
    logic                  phase_q, phase_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;

    note_t                 rom_note;
    logic                  trig_ready;
    logic                  trig_fire;
    logic [DUR_WIDTH-1:0]  decay_steps;
    logic [2:0]            decay_shift;
    logic [DATA_WIDTH-1:0] amp;
    logic [DATA_WIDTH-1:0] play_sample;

    sfx_note_rom u_note_rom (
        .code (code_q),
        .idx  (idx_q),
        .note (rom_note)
    );

    // equal or higher code preempts the running effect, lower codes are refused
    assign trig_ready = (state_q == ST_IDLE) || (bus.iTrig_Code >= code_q);
    assign trig_fire  = bus.iTrig_Valid && trig_ready;

    assign decay_steps = elapsed_q >> DECAY_LOG2;
    assign decay_shift = (decay_steps > DUR_WIDTH'(7)) ? 3'd7 : decay_steps[2:0];
    assign amp         = AMP_MAX >> decay_shift;
    assign play_sample = phase_q ? amp : (~amp + 1'b1);

    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        idx_d          = idx_q;
        hp_d           = hp_q;
        dur_d          = dur_q;
        phase_cnt_d    = phase_cnt_q;
        elapsed_d      = elapsed_q;
        phase_d        = phase_q;
        sample_d       = sample_q;
        sample_valid_d = bus.iSample_Tick;

        // the sample always reflects the state before any transition this cycle
        if (bus.iSample_Tick) begin
            sample_d = (state_q == ST_PLAY) ? play_sample : '0;
        end

        case (state_q)
            ST_IDLE: begin
            end
            ST_LOAD: begin
                phase_cnt_d = '0;
                elapsed_d   = '0;
                phase_d     = 1'b1;
                hp_d        = rom_note.half_period;
                dur_d       = rom_note.duration;
                state_d     = (rom_note.half_period == '0) ? ST_IDLE : ST_PLAY;
            end
            ST_PLAY: begin
                if (bus.iSample_Tick) begin
                    if (phase_cnt_q == hp_q - HP_WIDTH'(1)) begin
                        phase_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        phase_cnt_d = phase_cnt_q + HP_WIDTH'(1);
                    end
                    if (elapsed_q == dur_q - DUR_WIDTH'(1)) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + IDX_WIDTH'(1);
                            state_d = ST_LOAD;
                        end
                    end else begin
                        elapsed_d = elapsed_q + DUR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (trig_fire) begin
            state_d = ST_LOAD;
            code_d  = bus.iTrig_Code;
            idx_d   = '0;
        end
    end

    always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q        <= ST_IDLE;
            code_q         <= '0;
            idx_q          <= '0;
            hp_q           <= '0;
            dur_q          <= '0;
            phase_cnt_q    <= '0;
            elapsed_q      <= '0;
            phase_q        <= 1'b1;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            idx_q          <= idx_d;
            hp_q           <= hp_d;
            dur_q          <= dur_d;
            phase_cnt_q    <= phase_cnt_d;
            elapsed_q      <= elapsed_d;
            phase_q        <= phase_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign bus.oTrig_Ready   = trig_ready;
    assign bus.oSample       = sample_q;
    assign bus.oSample_Valid = sample_valid_q;
    assign bus.oBusy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sfx_tone_sequencer.sv
// tb/tb_sfx_tone_sequencer.sv - scoreboard bench for the sound-effect tone sequencer
module tb_sfx_tone_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n_pop = 0;
    logic [15:0] sb[$];

    sfx_tone_sequencer_if #(.DATA_WIDTH(16)) bus ();

    sfx_tone_sequencer dut (
        .iCLK_18_4 (clk),
        .iRST_N    (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_sample(input int hp, input int k);
        int sh;
        int a;
        sh = k / 512;
        if (sh > 7) sh = 7;
        a = 16383 >> sh;
        return ((k / hp) % 2 == 0) ? 16'(a) : 16'(-a);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input bit tk, input bit tv, input logic [1:0] c);
        bus.iSample_Tick = tk;
        bus.iTrig_Valid  = tv;
        bus.iTrig_Code   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic try_trig(input logic [1:0] c, input int exp_ready, input bit tk);
        bus.iSample_Tick = tk;
        bus.iTrig_Valid  = 1'b1;
        bus.iTrig_Code   = c;
        #1;
        chk("trig_ready", int'(bus.oTrig_Ready), exp_ready);
        @(posedge clk);
        #1;
        bus.iSample_Tick = 1'b0;
        bus.iTrig_Valid  = 1'b0;
    endtask

    task automatic play_note(input int hp, input int dur, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            if (k == dur - 1) chk("busy_last_sample", int'(bus.oBusy), 1);
            sb.push_back(exp_sample(hp, k));
            step(1'b1, 1'b0, 2'd0);
            step(1'b0, 1'b0, 2'd0);
        end
    endtask

    // monitor: every sample strobe consumes one expectation
    always @(negedge clk) begin
        if (bus.oSample_Valid) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sample_unexpected: got %0d expected no strobe at %0t",
                         $signed(bus.oSample), $time);
            end else begin
                logic [15:0] e;
                e = sb.pop_front();
                if (bus.oSample !== e) begin
                    bad++;
                    $display("FAIL sample[%0d]: got %0d expected %0d at %0t",
                             n_pop, $signed(bus.oSample), $signed(e), $time);
                end
                n_pop++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iSample_Tick = 1'b0;
        bus.iTrig_Valid  = 1'b0;
        bus.iTrig_Code   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sample", int'(bus.oSample), 0);
        chk("rst_valid", int'(bus.oSample_Valid), 0);
        chk("rst_busy", int'(bus.oBusy), 0);
        chk("rst_ready", int'(bus.oTrig_Ready), 1);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            sb.push_back(16'd0);
            step(1'b1, 1'b0, 2'd0);
            repeat (383) step(1'b0, 1'b0, 2'd0);
            chk("idle_busy", int'(bus.oBusy), 0);
            chk("idle_ready", int'(bus.oTrig_Ready), 1);
        end

        try_trig(2'd0, 1, 1'b0);
        chk("load_busy", int'(bus.oBusy), 1);
        step(1'b0, 1'b0, 2'd0);
        play_note(24, 2400, 0, 2400);
        chk("paddle_done_busy", int'(bus.oBusy), 0);

        try_trig(2'd1, 1, 1'b0);
        step(1'b0, 1'b0, 2'd0);
        play_note(12, 1440, 0, 1440);
        chk("brick_mid_busy", int'(bus.oBusy), 1);
        play_note(8, 1440, 0, 1440);
        chk("brick_done_busy", int'(bus.oBusy), 0);

        try_trig(2'd2, 1, 1'b0);
        step(1'b0, 1'b0, 2'd0);
        play_note(48, 4800, 0, 700);
        try_trig(2'd0, 0, 1'b0);
        play_note(48, 4800, 700, 1000);
        try_trig(2'd3, 1, 1'b0);
        step(1'b0, 1'b0, 2'd0);
        play_note(24, 2400, 0, 600);

        sb.push_back(exp_sample(24, 600));
        try_trig(2'd3, 1, 1'b1);
        sb.push_back(16'd0);
        step(1'b1, 1'b0, 2'd0);
        play_note(24, 2400, 0, 2400);
        play_note(18, 2400, 0, 2400);
        play_note(12, 2400, 0, 2400);
        play_note(9, 4800, 0, 4800);
        chk("clear_done_busy", int'(bus.oBusy), 0);

        try_trig(2'd2, 1, 1'b0);
        step(1'b0, 1'b0, 2'd0);
        play_note(48, 4800, 0, 300);
        chk("pre_rst_sample", int'(bus.oSample), 16383);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sample", int'(bus.oSample), 0);
        chk("async_rst_busy", int'(bus.oBusy), 0);
        chk("async_rst_ready", int'(bus.oTrig_Ready), 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(16'd0);
            step(1'b1, 1'b0, 2'd0);
            step(1'b0, 1'b0, 2'd0);
        end
        chk("post_rst_busy", int'(bus.oBusy), 0);
        repeat (4) step(1'b0, 1'b0, 2'd0);
        chk("sb_drained", sb.size(), 0);
        chk("strobe_count", n_pop, 3 + 2400 + 2880 + 1000 + 600 + 2 + 12000 + 300 + 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
